// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants and state encoding for the IF-stage fetch sequencer.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

  localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] C_EXC_VEC  = 32'h0000_4180;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : IF-stage fetch sequencer for variable-latency instruction memory,
//            one outstanding fetch, one-entry output register, redirect squash.
// Revision : 1.0
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC,
  parameter logic [31:0] EXC_VEC  = C_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_rready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;

  logic         w_flush;
  logic [31:0]  w_target;
  logic         w_free;
  logic         w_accept;

  assign w_flush  = exc | redirect;
  assign w_target = exc ? EXC_VEC : word_align(redirect_pc);
  assign w_free   = !if_valid_q || !stall;

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign imem_rready = (state_q == S_DISCARD) || ((state_q == S_WAIT) && w_free);
  assign w_accept    = imem_rvalid && imem_rready;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end
    if (w_flush) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (w_flush) begin
          pc_d = w_target;
        end
        if (imem_gnt) begin
          state_d = w_flush ? S_DISCARD : S_WAIT;
        end
      end

      S_WAIT: begin
        if (w_accept) begin
          state_d = S_REQ;
          if (w_flush) begin
            pc_d = w_target;
          end else begin
            pc_d       = pc_q + 32'd4;
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
          end
        end else if (w_flush) begin
          // Response still owed by memory; it must be drained, not delivered.
          pc_d    = w_target;
          state_d = S_DISCARD;
        end
      end

      S_DISCARD: begin
        if (w_flush) begin
          pc_d = w_target;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Scoreboard bench for fetch_ctrl with a behavioural variable-latency memory.
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

  logic        clk         = 1'b0;
  logic        reset       = 1'b0;
  logic        stall       = 1'b0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        exc         = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt    = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        imem_rready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC(32'h0000_3000),
    .EXC_VEC (32'h0000_4180)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .exc        (exc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .imem_rready(imem_rready),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_out_q[$];

  // Memory model controls (written by stimulus) and handshake record (negedge).
  int grants_allowed = 0;
  int grants_done    = 0;
  int gnt_wait       = 0;
  int rsp_lat        = 1;
  int req_cnt        = 0;
  int lat_cnt        = 0;
  bit pend           = 1'b0;
  logic [31:0] pend_addr = '0;
  bit rst_seen = 1'b1;
  bit hs_req   = 1'b0;
  bit hs_rsp   = 1'b0;
  logic [31:0] hs_addr = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid_pc(input logic [31:0] pc, input string name);
    int n = 0;
    while (!(if_valid === 1'b1 && if_pc === pc) && n < 30) begin
      tick(1);
      n++;
    end
    checks++;
    if (!(if_valid === 1'b1 && if_pc === pc)) begin
      errors++;
      $display("FAIL %s: if_valid=%b if_pc=%h, required if_valid=1 if_pc=%h within 30 cycles",
               name, if_valid, if_pc, pc);
    end
  endtask

  task automatic wait_req_low(input string name);
    int n = 0;
    while (imem_req !== 1'b0 && n < 30) begin
      tick(1);
      n++;
    end
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s: imem_req=%b, required 0 within 30 cycles", name, imem_req);
    end
  endtask

  task automatic wait_out_drained(input string name);
    int n = 0;
    while (exp_out_q.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_out_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected deliveries outstanding, required 0 within 40 cycles",
               name, exp_out_q.size());
    end
  endtask

  // Monitor: records handshakes for the memory model and scores DUT outputs.
  always @(negedge clk) begin
    logic [63:0] e;
    rst_seen = !reset;
    hs_req   = imem_req && imem_gnt;
    hs_addr  = imem_addr;
    hs_rsp   = imem_rvalid && imem_rready;
    if (reset) begin
      check32("req_with_rready", {31'd0, imem_req && imem_rready}, 32'd0);
      if (hs_req) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_addr: unexpected grant at %h, required no request", imem_addr);
        end else begin
          check32("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (if_valid && !stall) begin
        if (exp_out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL delivery: unexpected pc=%h instr=%h, required none", if_pc, if_instr);
        end else begin
          e = exp_out_q.pop_front();
          check32("deliver_pc", if_pc, e[63:32]);
          check32("deliver_instr", if_instr, e[31:0]);
        end
      end
    end
  end

  // Memory: grants gated by a budget and a wait count, holds rvalid until rready.
  always @(posedge clk) begin
    #1;
    if (rst_seen) begin
      pend        = 1'b0;
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b0;
      req_cnt     = 0;
    end else begin
      if (hs_rsp) begin
        imem_rvalid = 1'b0;
        pend        = 1'b0;
      end
      if (hs_req) begin
        pend      = 1'b1;
        pend_addr = hs_addr;
        lat_cnt   = rsp_lat;
        req_cnt   = 0;
        grants_done++;
      end
      if (pend && !imem_rvalid) begin
        if (lat_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_addr ^ 32'hDEAD_0000;
        end else begin
          lat_cnt--;
        end
      end
      imem_gnt = 1'b0;
      if (imem_req && grants_done < grants_allowed) begin
        if (req_cnt >= gnt_wait) imem_gnt = 1'b1;
        else req_cnt++;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    reset = 1'b0;
    tick(3);
    check32("rst_req", {31'd0, imem_req}, 32'd1);
    check32("rst_addr", imem_addr, 32'h0000_3000);
    check32("rst_rready", {31'd0, imem_rready}, 32'd0);
    check32("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check32("rst_if_pc", if_pc, 32'd0);
    check32("rst_if_instr", if_instr, 32'd0);

    // Sequential fetch, then stall with a response pending
    grants_allowed = 3;
    exp_addr_q.push_back(32'h0000_3000);
    exp_addr_q.push_back(32'h0000_3004);
    exp_addr_q.push_back(32'h0000_3008);
    exp_out_q.push_back({32'h0000_3000, 32'hDEAD_3000});
    exp_out_q.push_back({32'h0000_3004, 32'hDEAD_3004});
    exp_out_q.push_back({32'h0000_3008, 32'hDEAD_3008});
    reset = 1'b1;
    wait_valid_pc(32'h0000_3000, "t1_first_fetch");
    tick(2);
    check32("t1_cadence_valid", {31'd0, if_valid}, 32'd1);
    check32("t1_cadence_pc", if_pc, 32'h0000_3004);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check32("t2_stall_rready", {31'd0, imem_rready}, 32'd0);
      check32("t2_stall_req", {31'd0, imem_req}, 32'd0);
      check32("t2_stall_pc", if_pc, 32'h0000_3004);
      check32("t2_stall_instr", if_instr, 32'hDEAD_3004);
    end
    stall = 1'b0;
    wait_out_drained("t2_release");

    // Redirect while waiting; stale response must be dropped
    rsp_lat = 3;
    grants_allowed += 2;
    exp_addr_q.push_back(32'h0000_300C);
    exp_addr_q.push_back(32'h0000_3100);
    exp_out_q.push_back({32'h0000_3100, 32'hDEAD_3100});
    wait_req_low("t3_enter_wait");
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3103;
    rsp_lat     = 1;
    tick(1);
    redirect = 1'b0;
    check32("t3_discard_req", {31'd0, imem_req}, 32'd0);
    check32("t3_discard_rready", {31'd0, imem_rready}, 32'd1);
    check32("t3_discard_addr", imem_addr, 32'h0000_3100);
    check32("t3_discard_valid", {31'd0, if_valid}, 32'd0);
    wait_out_drained("t3_refetch");

    // exc and redirect together on the grant cycle
    grants_allowed += 1;
    exp_addr_q.push_back(32'h0000_3104);
    exp_addr_q.push_back(32'h0000_4180);
    exp_out_q.push_back({32'h0000_4180, 32'hDEAD_4180});
    tick(1);
    exc         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3200;
    check32("t4_grant_addr", imem_addr, 32'h0000_3104);
    tick(1);
    exc      = 1'b0;
    redirect = 1'b0;
    check32("t4_discard_req", {31'd0, imem_req}, 32'd0);
    check32("t4_discard_rready", {31'd0, imem_rready}, 32'd1);
    check32("t4_exc_addr", imem_addr, 32'h0000_4180);
    tick(1);
    check32("t4_req_again", {31'd0, imem_req}, 32'd1);
    check32("t4_req_addr", imem_addr, 32'h0000_4180);
    grants_allowed += 1;
    wait_out_drained("t4_vector_fetch");

    // Redirect while ungranted, then reset in the middle of a wait
    gnt_wait = 4;
    grants_allowed += 2;
    exp_addr_q.push_back(32'h0000_3040);
    exp_addr_q.push_back(32'h0000_3044);
    tick(2);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3040;
    tick(1);
    redirect = 1'b0;
    check32("t5_still_req", {31'd0, imem_req}, 32'd1);
    check32("t5_new_addr", imem_addr, 32'h0000_3040);
    check32("t5_no_rready", {31'd0, imem_rready}, 32'd0);
    wait_valid_pc(32'h0000_3040, "t5_redirect_fetch");
    stall = 1'b1;
    check32("t5_instr", if_instr, 32'hDEAD_3040);
    wait_req_low("t5_second_grant");
    check32("t5_held_pc", if_pc, 32'h0000_3040);
    reset = 1'b0;
    tick(1);
    check32("t5_rst_req", {31'd0, imem_req}, 32'd1);
    check32("t5_rst_addr", imem_addr, 32'h0000_3000);
    check32("t5_rst_rready", {31'd0, imem_rready}, 32'd0);
    check32("t5_rst_valid", {31'd0, if_valid}, 32'd0);
    check32("t5_rst_pc", if_pc, 32'd0);
    check32("t5_rst_instr", if_instr, 32'd0);
    reset    = 1'b1;
    stall    = 1'b0;
    gnt_wait = 0;
    tick(1);

    // Wrap past the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    check32("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    exp_out_q.push_back({32'hFFFF_FFFC, 32'h2152_FFFC});
    exp_out_q.push_back({32'h0000_0000, 32'hDEAD_0000});
    grants_allowed += 2;
    wait_out_drained("t6_wrap");
    check32("t6_next_addr", imem_addr, 32'h0000_0004);
    check32("t6_next_req", {31'd0, imem_req}, 32'd1);

    tick(3);
    check32("addr_queue_empty", exp_addr_q.size(), 32'd0);
    check32("out_queue_empty", exp_out_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
